ram_sync: RTL and testbench
===========================

RAM_SYNC -- requirements
Module: ram_sync

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the word width in bits; it must be a multiple of 8.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 7, the address width; DEPTH = 2**ADDR_WIDTH words, 128 by default.
REQ-003 The module SHALL have parameter INIT_CLEAR, default 1; when 1, memory is zero-filled after every reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The module SHALL have port req, input, 1 bit: access request, sampled each rising edge.
REQ-007 The module SHALL have port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-008 The module SHALL have port be, input, DATA_WIDTH/8 bits: byte-lane write enables; bit i covers data bits [8i+7:8i].
REQ-009 The module SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-010 The module SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-011 The module SHALL have port rdata, output, DATA_WIDTH bits: registered read data.
REQ-012 The module SHALL have port rvalid, output, 1 bit: one-cycle pulse marking rdata as new read data.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a clear sequence runs; requests are not accepted.
REQ-014 The module SHALL use separate wdata/rdata buses; no bidirectional or tri-state data port.

Function
REQ-015 The module SHALL implement an FSM with states CLEAR and IDLE; busy = 1 in CLEAR and busy = 0 in IDLE.
REQ-016 In CLEAR, the module SHALL write all-zero to word clr_cnt each cycle and increment clr_cnt; clr_cnt is ADDR_WIDTH bits and starts at 0.
REQ-017 On the cycle clr_cnt = DEPTH-1, the module SHALL write that word and enter IDLE at the next edge; the clear lasts exactly DEPTH cycles after rst deasserts.
REQ-018 When req=1, we=1 and busy=0, the module SHALL update, at that edge, only the byte lanes of mem[addr] whose be bit is 1; be=0 leaves the word unchanged.
REQ-019 A write SHALL NOT change rdata and SHALL NOT assert rvalid.
REQ-020 When req=1, we=0 and busy=0, the module SHALL load rdata with mem[addr] at that edge and assert rvalid for that cycle only; latency is 1 cycle.
REQ-021 The be input SHALL be ignored for reads.
REQ-022 A read of an address written in the previous cycle SHALL return the new data.
REQ-023 Back-to-back reads SHALL be accepted every cycle, with rvalid held high for consecutive cycles.
REQ-024 When no read is accepted, the module SHALL deassert rvalid and hold rdata at its last value.
REQ-025 Requests with busy=1 SHALL be ignored: no memory write and no rvalid, and they are not queued.
REQ-026 Every addr value SHALL be valid; there is no out-of-range case, and the address wraps naturally with its width.

Reset
REQ-027 While rst=1 at an edge, the module SHALL set rdata=0, rvalid=0 and clr_cnt=0.
REQ-028 While rst=1, the FSM SHALL be held in CLEAR if INIT_CLEAR=1, otherwise in IDLE; busy follows from the state.
REQ-029 While rst=1, any req SHALL be ignored.
REQ-030 Reset asserted mid-clear SHALL restart the clear from word 0.
REQ-031 A read accepted in the cycle before rst asserts SHALL produce no rvalid once rst is sampled high.
REQ-032 With INIT_CLEAR=0, memory contents SHALL be unaffected by reset.

Verification
REQ-033 Scenario "reset clear", defaults: rst for 2 cycles then release -> busy=1 for exactly 128 cycles, then 0; a read of addr 0x7F returns 0x00000000 with rvalid 1 cycle later.
REQ-034 Scenario "write then read": write 0xBBBBBBBB to addr 0, then 0xAAAAAAAA to addr 1 (be=4'hF), then read addr 0 then addr 1 -> rdata 0xBBBBBBBB then 0xAAAAAAAA on consecutive cycles, rvalid high for 2 cycles.
REQ-035 Scenario "byte enables": addr 5 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
REQ-036 Scenario "busy masking": write 0xDEADBEEF to addr 3 while busy=1 -> no effect; after clear, read addr 3 returns 0 and no rvalid occurs during busy.
REQ-037 Scenario "reset mid-clear": assert rst when clr_cnt=60 -> clear restarts at 0 and busy stays high for a further 128 cycles after release.
REQ-038 Scenario "parameter sweep": DATA_WIDTH=16, ADDR_WIDTH=4, INIT_CLEAR=0 -> 16 words, 2 byte lanes, busy=0 immediately after reset, and data written before reset is still readable after reset.

Source files
------------

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with byte-lane writes and a zero-fill sequence after reset.
// Latency: reads return 1 cycle after acceptance; backpressure: busy is high during the clear, and requests are dropped there, not queued.
module ram_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int INIT_CLEAR = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    busy
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    clr_we;
    logic                    acc_wr;
    logic                    acc_rd;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reset gates every enable so requests presented alongside rst are dropped.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        clr_we     = 1'b0;
        acc_wr     = 1'b0;
        acc_rd     = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = !rst;
                if (clr_cnt == LAST_ADDR) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                acc_wr = req && we && !rst;
                acc_rd = req && !we && !rst;
            end
        endcase
    end

    // Counter wraps back to 0 on the last word, ready for the next clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (clr_we) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (acc_wr) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= acc_rd;
            if (acc_rd) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// Directed bench for ram_sync: default instance plus a 16-bit / 16-word instance without clear.
module tb_ram_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we;
    logic [3:0]  be;
    logic [6:0]  addr;
    logic [31:0] wdata, rdata;
    logic        rvalid, busy;

    logic        rst1, req1, we1;
    logic [1:0]  be1;
    logic [3:0]  addr1;
    logic [15:0] wdata1, rdata1;
    logic        rvalid1, busy1;

    int checks   = 0;
    int failures = 0;
    int n;
    bit saw_rv;

    ram_sync u0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    ram_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .INIT_CLEAR(0)) u1 (
        .clk(clk), .rst(rst1), .req(req1), .we(we1), .be(be1), .addr(addr1),
        .wdata(wdata1), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic r, input logic w, input logic [3:0] b,
                      input logic [6:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic op1(input logic r, input logic w, input logic [1:0] b,
                       input logic [3:0] a, input logic [15:0] d);
        req1 = r; we1 = w; be1 = b; addr1 = a; wdata1 = d;
    endtask

    // Counts cycles until busy drops; optionally fires writes/reads to addr 3 meanwhile.
    task automatic count_busy(input bit poke, output int cnt, output bit rv);
        cnt = 0;
        rv  = 1'b0;
        while (busy === 1'b1 && cnt < 1000) begin
            if (poke) op(1'b1, (cnt % 2 == 0), 4'hF, 7'h03, 32'hDEADBEEF);
            tick();
            cnt++;
            if (rvalid !== 1'b0) rv = 1'b1;
        end
        op(1'b0, 1'b0, 4'h0, 7'h00, 32'h0);
    endtask

    initial begin
        op(1'b0, 1'b0, 4'h0, 7'h00, 32'h0);
        op1(1'b0, 1'b0, 2'h0, 4'h0, 16'h0);
        rst  = 1'b1;
        rst1 = 1'b1;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("p_rst_busy", {31'b0, busy1}, 32'd0);
        rst  = 1'b0;
        rst1 = 1'b0;

        // reset clear with busy masking traffic
        count_busy(1'b1, n, saw_rv);
        check("clear_cycles", n, 32'd128);
        check("busy_no_rvalid", {31'b0, saw_rv}, 32'd0);
        check("busy_done", {31'b0, busy}, 32'd0);

        op(1'b1, 1'b0, 4'h0, 7'h7F, 32'h0);
        tick();
        check("rd7f_rvalid", {31'b0, rvalid}, 32'd1);
        check("rd7f_data", rdata, 32'h0);
        op(1'b1, 1'b0, 4'h0, 7'h03, 32'h0);
        tick();
        check("rd3_masked_data", rdata, 32'h0);
        check("rd3_rvalid", {31'b0, rvalid}, 32'd1);
        op(1'b0, 1'b0, 4'h0, 7'h00, 32'h0);
        tick();
        check("idle_rvalid", {31'b0, rvalid}, 32'd0);

        // write then read
        op(1'b1, 1'b1, 4'hF, 7'h00, 32'hBBBBBBBB);
        tick();
        check("wr_no_rvalid", {31'b0, rvalid}, 32'd0);
        check("wr_rdata_kept", rdata, 32'h0);
        op(1'b1, 1'b1, 4'hF, 7'h01, 32'hAAAAAAAA);
        tick();
        op(1'b1, 1'b0, 4'h0, 7'h00, 32'h0);
        tick();
        check("b2b_rd0_data", rdata, 32'hBBBBBBBB);
        check("b2b_rd0_rvalid", {31'b0, rvalid}, 32'd1);
        op(1'b1, 1'b0, 4'h0, 7'h01, 32'h0);
        tick();
        check("b2b_rd1_data", rdata, 32'hAAAAAAAA);
        check("b2b_rd1_rvalid", {31'b0, rvalid}, 32'd1);
        op(1'b0, 1'b0, 4'h0, 7'h00, 32'h0);
        tick();
        check("hold_rvalid", {31'b0, rvalid}, 32'd0);
        check("hold_rdata", rdata, 32'hAAAAAAAA);

        // byte enables; read right after write sees new data, be ignored on read
        op(1'b1, 1'b1, 4'hF, 7'h05, 32'h11223344);
        tick();
        op(1'b1, 1'b1, 4'b0101, 7'h05, 32'hAABBCCDD);
        tick();
        op(1'b1, 1'b0, 4'hA, 7'h05, 32'h0);
        tick();
        check("be_merge", rdata, 32'h11BB33DD);
        op(1'b1, 1'b1, 4'h0, 7'h05, 32'hFFFFFFFF);
        tick();
        op(1'b1, 1'b0, 4'h0, 7'h05, 32'h0);
        tick();
        check("be_zero_nochange", rdata, 32'h11BB33DD);
        check("rd_before_rst_rvalid", {31'b0, rvalid}, 32'd1);

        // read pending into reset, then reset mid-clear
        rst = 1'b1;
        tick();
        check("rst_kills_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata_zero", rdata, 32'h0);
        check("rst_busy_again", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        op(1'b0, 1'b0, 4'h0, 7'h00, 32'h0);
        repeat (60) tick();
        check("mid_clear_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(1'b0, n, saw_rv);
        check("restart_cycles", n, 32'd128);
        op(1'b1, 1'b0, 4'h0, 7'h05, 32'h0);
        tick();
        check("after_clear_rd5", rdata, 32'h0);
        check("after_clear_rvalid", {31'b0, rvalid}, 32'd1);
        op(1'b0, 1'b0, 4'h0, 7'h00, 32'h0);

        // parameter sweep instance: no clear, contents survive reset
        check("p_busy_idle", {31'b0, busy1}, 32'd0);
        op1(1'b1, 1'b1, 2'b11, 4'hF, 16'hBEEF);
        tick();
        op1(1'b1, 1'b1, 2'b11, 4'h2, 16'h1234);
        tick();
        op1(1'b1, 1'b1, 2'b10, 4'h2, 16'hAB55);
        tick();
        op1(1'b1, 1'b0, 2'b00, 4'h2, 16'h0);
        tick();
        check("p_be_merge", {16'h0, rdata1}, 32'h0000AB34);
        check("p_rvalid", {31'b0, rvalid1}, 32'd1);
        op1(1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
        rst1 = 1'b1;
        tick();
        tick();
        check("p_rst_rdata", {16'h0, rdata1}, 32'h0);
        check("p_rst_busy2", {31'b0, busy1}, 32'd0);
        rst1 = 1'b0;
        op1(1'b1, 1'b0, 2'b00, 4'hF, 16'h0);
        tick();
        check("p_keep_f", {16'h0, rdata1}, 32'h0000BEEF);
        check("p_keep_f_rvalid", {31'b0, rvalid1}, 32'd1);
        op1(1'b1, 1'b0, 2'b00, 4'h2, 16'h0);
        tick();
        check("p_keep_2", {16'h0, rdata1}, 32'h0000AB34);
        op1(1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
        tick();
        check("p_idle_rvalid", {31'b0, rvalid1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
